// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and baud divisor helper.
// Used by the receiver now and by future UART blocks.
package uart_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        START = ST_START,
        DATA  = ST_DATA,
        STOP  = ST_STOP
    } uart_state_t;

    // Result must lie in 4..65535 so it fits the 16-bit baud counter.
    function automatic int unsigned calc_baud_cnt_max(input int unsigned clk_freq,
                                                      input int unsigned uart_bps);
        return clk_freq / uart_bps;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit, with selectable reset value.
module sync_2ff #(
    parameter logic INIT = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic d0;

    // Capture stage then resolve stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d0 <= INIT;
            q  <= INIT;
        end else begin
            d0 <= d;
            q  <= d0;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first; mid-bit sampling, done strobe per good byte,
// error strobe on a zero stop bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned UART_BPS = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rxd,
    output logic [7:0] uart_rx_data,
    output logic       uart_rx_done,
    output logic       uart_rx_err,
    output logic       uart_rx_busy
);

    localparam int unsigned BAUD_CNT_MAX = calc_baud_cnt_max(CLK_FREQ, UART_BPS);
    localparam int unsigned HALF_CNT     = BAUD_CNT_MAX / 2;
    localparam logic [15:0] BAUD_LAST    = 16'(BAUD_CNT_MAX - 1);
    localparam logic [15:0] HALF_LAST    = 16'(HALF_CNT - 1);

    uart_state_t state, next_state;
    logic        rxd_d1;
    logic        rxd_d2;
    logic        start_cond;
    logic [15:0] baud_cnt, baud_cnt_nxt;
    logic [2:0]  bit_cnt, bit_cnt_nxt;
    logic [7:0]  shift_reg, shift_nxt;
    logic [7:0]  data_nxt;
    logic        done_nxt, err_nxt, busy_nxt;

    sync_2ff #(.INIT(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (uart_rxd),
        .q   (rxd_d1)
    );

    // Only a genuine falling edge starts a frame, so a line stuck low stays idle.
    assign start_cond = (rxd_d1 == 1'b0) && (rxd_d2 == 1'b1);

    // Next-state, counters, shifter and output strobes.
    always_comb begin
        next_state   = state;
        baud_cnt_nxt = baud_cnt;
        bit_cnt_nxt  = bit_cnt;
        shift_nxt    = shift_reg;
        data_nxt     = uart_rx_data;
        done_nxt     = 1'b0;
        err_nxt      = 1'b0;
        case (state)
            IDLE: begin
                baud_cnt_nxt = 16'd0;
                bit_cnt_nxt  = 3'd0;
                if (start_cond) begin
                    next_state = START;
                end else begin
                    next_state = IDLE;
                end
            end
            START: begin
                if (baud_cnt == HALF_LAST) begin
                    baud_cnt_nxt = 16'd0;
                    bit_cnt_nxt  = 3'd0;
                    if (rxd_d1 == 1'b0) begin
                        next_state = DATA;
                    end else begin
                        next_state = IDLE;
                    end
                end else begin
                    baud_cnt_nxt = baud_cnt + 16'd1;
                end
            end
            DATA: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_cnt_nxt = 16'd0;
                    shift_nxt    = {rxd_d1, shift_reg[7:1]};
                    bit_cnt_nxt  = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        next_state = STOP;
                    end else begin
                        next_state = DATA;
                    end
                end else begin
                    baud_cnt_nxt = baud_cnt + 16'd1;
                end
            end
            STOP: begin
                // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start edge.
                if (baud_cnt == BAUD_LAST) begin
                    baud_cnt_nxt = 16'd0;
                    next_state   = IDLE;
                    if (rxd_d1 == 1'b1) begin
                        data_nxt = shift_reg;
                        done_nxt = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end else begin
                    baud_cnt_nxt = baud_cnt + 16'd1;
                end
            end
            default: begin
                next_state   = IDLE;
                baud_cnt_nxt = 16'd0;
                bit_cnt_nxt  = 3'd0;
            end
        endcase
        busy_nxt = (next_state != IDLE);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            rxd_d2       <= 1'b1;
            baud_cnt     <= 16'd0;
            bit_cnt      <= 3'd0;
            shift_reg    <= 8'h00;
            uart_rx_data <= 8'h00;
            uart_rx_done <= 1'b0;
            uart_rx_err  <= 1'b0;
            uart_rx_busy <= 1'b0;
        end else begin
            state        <= next_state;
            rxd_d2       <= rxd_d1;
            baud_cnt     <= baud_cnt_nxt;
            bit_cnt      <= bit_cnt_nxt;
            shift_reg    <= shift_nxt;
            uart_rx_data <= data_nxt;
            uart_rx_done <= done_nxt;
            uart_rx_err  <= err_nxt;
            uart_rx_busy <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at default parameters: table of single frames plus
// back-to-back, glitch and mid-frame reset sequences.
module tb_uart_rx;

    localparam int BIT = 434;
    localparam int LAT = 4125;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_rxd = 1'b1;
    logic [7:0] uart_rx_data;
    logic       uart_rx_done;
    logic       uart_rx_err;
    logic       uart_rx_busy;

    uart_rx #(.CLK_FREQ(50000000), .UART_BPS(115200)) dut (
        .clk          (clk),
        .rst          (rst),
        .uart_rxd     (uart_rxd),
        .uart_rx_data (uart_rx_data),
        .uart_rx_done (uart_rx_done),
        .uart_rx_err  (uart_rx_err),
        .uart_rx_busy (uart_rx_busy)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int       done_cnt = 0, err_cnt = 0, both_cnt = 0, busy_rises = 0;
    int       busy_rise = 0, busy_last = 0;
    logic     busy_prev = 1'b0;
    int       done_cyc [0:63];
    int       err_cyc  [0:63];
    logic [7:0] done_dat [0:63];

    // Event log of output strobes and busy span, sampled away from the active edge.
    always @(negedge clk) begin
        if (uart_rx_done === 1'b1) begin
            if (done_cnt < 64) begin
                done_cyc[done_cnt] = cyc;
                done_dat[done_cnt] = uart_rx_data;
            end
            done_cnt = done_cnt + 1;
        end
        if (uart_rx_err === 1'b1) begin
            if (err_cnt < 64) err_cyc[err_cnt] = cyc;
            err_cnt = err_cnt + 1;
        end
        if (uart_rx_done === 1'b1 && uart_rx_err === 1'b1) both_cnt = both_cnt + 1;
        if (uart_rx_busy === 1'b1 && busy_prev !== 1'b1) begin
            busy_rises = busy_rises + 1;
            busy_rise  = cyc;
        end
        if (uart_rx_busy === 1'b1) busy_last = cyc;
        busy_prev = uart_rx_busy;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Call at a negedge; t0 is the edge at which the synchroniser captures the start bit.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int per, output int t0);
        logic [9:0] frame;
        frame = {stop, d, 1'b0};
        t0 = cyc + 1;
        for (int i = 0; i < 10; i++) begin
            uart_rxd = frame[i];
            repeat (per) @(negedge clk);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         per;
        int         low_after;
        logic       exp_done;
        logic       exp_err;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int t0, ta, tb, tc, d0, e0, r0;
        logic [9:0] fr;

        vecs[0] = '{8'h96, 1'b1, 425, 0,       1'b1, 1'b0, 8'h96};
        vecs[1] = '{8'hA5, 1'b1, 434, 0,       1'b1, 1'b0, 8'hA5};
        vecs[2] = '{8'h3C, 1'b0, 434, 2 * BIT, 1'b0, 1'b1, 8'hA5};
        vecs[3] = '{8'h96, 1'b1, 443, 0,       1'b1, 1'b0, 8'h96};

        idle(5);
        chk("reset_data", 32'(uart_rx_data), 32'h00);
        chk("reset_done", 32'(uart_rx_done), 32'h0);
        chk("reset_err",  32'(uart_rx_err),  32'h0);
        chk("reset_busy", 32'(uart_rx_busy), 32'h0);
        rst = 1'b0;
        idle(20);

        for (int v = 0; v < 4; v++) begin
            d0 = done_cnt; e0 = err_cnt; r0 = busy_rises;
            send_frame(vecs[v].data, vecs[v].stop, vecs[v].per, t0);
            if (vecs[v].low_after > 0) begin
                idle(vecs[v].low_after);
                uart_rxd = 1'b1;
            end
            idle(3 * BIT);
            chk($sformatf("v%0d_done_count", v), 32'(done_cnt - d0), 32'(vecs[v].exp_done));
            chk($sformatf("v%0d_err_count", v),  32'(err_cnt - e0),  32'(vecs[v].exp_err));
            chk($sformatf("v%0d_data", v),       32'(uart_rx_data),  32'(vecs[v].exp_data));
            chk($sformatf("v%0d_busy_rises", v), 32'(busy_rises - r0), 32'd1);
            chk($sformatf("v%0d_busy_rise", v),  32'(busy_rise), 32'(t0 + 2));
            chk($sformatf("v%0d_busy_last", v),  32'(busy_last), 32'(t0 + LAT - 1));
            if (vecs[v].exp_done) begin
                chk($sformatf("v%0d_done_cycle", v), 32'(done_cyc[d0]), 32'(t0 + LAT));
                chk($sformatf("v%0d_done_data", v),  32'(done_dat[d0]), 32'(vecs[v].exp_data));
            end else begin
                chk($sformatf("v%0d_err_cycle", v), 32'(err_cyc[e0]), 32'(t0 + LAT));
            end
        end

        // Back-to-back frames with no idle gap.
        d0 = done_cnt; e0 = err_cnt;
        send_frame(8'h00, 1'b1, BIT, ta);
        send_frame(8'hFF, 1'b1, BIT, tb);
        send_frame(8'h55, 1'b1, BIT, tc);
        idle(3 * BIT);
        chk("b2b_done_count", 32'(done_cnt - d0), 32'd3);
        chk("b2b_err_count",  32'(err_cnt - e0),  32'd0);
        chk("b2b_first_cycle", 32'(done_cyc[d0]), 32'(ta + LAT));
        chk("b2b_gap1", 32'(done_cyc[d0 + 1] - done_cyc[d0]), 32'(10 * BIT));
        chk("b2b_gap2", 32'(done_cyc[d0 + 2] - done_cyc[d0 + 1]), 32'(10 * BIT));
        chk("b2b_data0", 32'(done_dat[d0]),     32'h00);
        chk("b2b_data1", 32'(done_dat[d0 + 1]), 32'hFF);
        chk("b2b_data2", 32'(done_dat[d0 + 2]), 32'h55);

        // Short low glitch on an idle line.
        d0 = done_cnt; e0 = err_cnt; r0 = busy_rises;
        uart_rxd = 1'b0;
        t0 = cyc + 1;
        idle(100);
        uart_rxd = 1'b1;
        idle(600);
        chk("glitch_busy_rises", 32'(busy_rises - r0), 32'd1);
        chk("glitch_busy_rise",  32'(busy_rise), 32'(t0 + 2));
        chk("glitch_busy_last",  32'(busy_last), 32'(t0 + 218));
        chk("glitch_done", 32'(done_cnt - d0), 32'd0);
        chk("glitch_err",  32'(err_cnt - e0),  32'd0);

        // Reset during data bit 4 of 8'hC3, then a clean 8'h81.
        d0 = done_cnt; e0 = err_cnt;
        fr = {1'b1, 8'hC3, 1'b0};
        for (int i = 0; i < 5; i++) begin
            uart_rxd = fr[i];
            idle(BIT);
        end
        uart_rxd = fr[5];
        idle(200);
        rst = 1'b1;
        idle(1);
        chk("rst_mid_data", 32'(uart_rx_data), 32'h00);
        chk("rst_mid_done", 32'(uart_rx_done), 32'h0);
        chk("rst_mid_err",  32'(uart_rx_err),  32'h0);
        chk("rst_mid_busy", 32'(uart_rx_busy), 32'h0);
        idle(2);
        rst = 1'b0;
        uart_rxd = 1'b1;
        idle(1000);
        chk("rst_abort_done", 32'(done_cnt - d0), 32'd0);
        chk("rst_abort_err",  32'(err_cnt - e0),  32'd0);
        send_frame(8'h81, 1'b1, BIT, t0);
        idle(3 * BIT);
        chk("after_rst_done_count", 32'(done_cnt - d0), 32'd1);
        chk("after_rst_done_cycle", 32'(done_cyc[d0]), 32'(t0 + LAT));
        chk("after_rst_data", 32'(uart_rx_data), 32'h81);

        chk("done_err_overlap", 32'(both_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver, 8N1, LSB first: the receive counterpart of the design's UART transmitter, sharing its `CLK_FREQ`/`UART_BPS` parameterisation.
- Synchronises the asynchronous `uart_rxd` line into `clk`.
- Validates the start bit at mid-bit and samples each data bit at mid-bit.
- Checks the stop bit and presents each received byte with a one-cycle done strobe.
- Sits between the board RX pin and the command/data parser.

## Interface
- `CLK_FREQ`, default 50000000: system clock frequency in Hz.
- `UART_BPS`, default 115200: baud rate.
- `clk`  input  1  system clock.
- `rst`  input  1  asynchronous, active-high reset.
- `uart_rxd`  input  1  serial line, asynchronous to `clk`, idles high.
- `uart_rx_data`  output  8  last good byte; holds until the next good frame.
- `uart_rx_done`  output  1  one-cycle pulse when `uart_rx_data` updates.
- `uart_rx_err`  output  1  one-cycle pulse on framing error (stop bit sampled 0).
- `uart_rx_busy`  output  1  high while a frame is being received.

## Operation
- Constants:
  - `BAUD_CNT_MAX = CLK_FREQ/UART_BPS` (integer divide).
  - `HALF_CNT = BAUD_CNT_MAX/2`.
  - `baud_cnt` is 16 bits wide; `BAUD_CNT_MAX` must be ≤ 65535 and ≥ 4.
- Synchroniser:
  - `rxd_d0` then `rxd_d1`, plus a history flop `rxd_d2`; all three reset to 1.
  - Start condition: `rxd_d1==0 && rxd_d2==1`.
- FSM states: IDLE, START, DATA, STOP. Reset state is IDLE.
- IDLE:
  - `baud_cnt=0`, `bit_cnt=0`.
  - On the start condition, go to START with `baud_cnt=0`.
  - A line held low never triggers a start; a falling edge is required.
- START:
  - `baud_cnt` increments each cycle.
  - When `baud_cnt==HALF_CNT-1`, sample `rxd_d1`:
    - 0: go to DATA with `baud_cnt=0`, `bit_cnt=0`.
    - 1: glitch; return to IDLE with no outputs asserted.
- DATA:
  - `baud_cnt` wraps at `BAUD_CNT_MAX-1`.
  - At each wrap, shift `rxd_d1` into `shift_reg[7]` (right shift, so the first bit lands in `shift_reg[0]`) and increment `bit_cnt`.
  - After the 8th sample (`bit_cnt==7` at wrap), go to STOP with `baud_cnt=0`.
- STOP: at `baud_cnt==BAUD_CNT_MAX-1`, sample `rxd_d1`, then go to IDLE.
  - 1: `uart_rx_data<=shift_reg`, `uart_rx_done<=1`.
  - 0: `uart_rx_err<=1`; `uart_rx_data` unchanged; no done.
- `uart_rx_busy` is 1 in START, DATA and STOP, and 0 in IDLE.
- Back-to-back frames:
  - Returning to IDLE at mid-stop-bit is what allows this.
  - A start edge arriving half a bit later is caught.
- Break or framing error: the line stays low, so no restart until the line has gone high and then fallen again.
- `uart_rx_done` and `uart_rx_err` are never high in the same cycle.

## Timing
- Reset values: `uart_rx_data=8'h00`, `uart_rx_done=0`, `uart_rx_err=0`, `uart_rx_busy=0`; synchroniser flops 1; FSM in IDLE.
- Assertion of `rst` mid-frame aborts immediately: the partial byte is discarded and no done/err pulse follows.
- Let t0 be the `clk` edge at which `rxd_d0` first captures 0:
  - START is entered at edge t0+2.
  - The start sample is taken at t0+2+`HALF_CNT`.
  - Data bit k (k=0..7) is sampled at t0+2+`HALF_CNT`+(k+1)·`BAUD_CNT_MAX`.
  - The stop sample is taken at t0+2+`HALF_CNT`+9·`BAUD_CNT_MAX`.
  - `uart_rx_done`/`uart_rx_err` are high for the single cycle after the stop-sample edge.
- Default-parameter latency is `BAUD_CNT_MAX=434`, `HALF_CNT=217`, giving done at t0+4125.
- `uart_rx_busy` rises at t0+2 and falls at the stop-sample edge (same edge that raises done).
- No backpressure: the consumer must take `uart_rx_data` on the `uart_rx_done` cycle or later, before the next done.

## Structure
- Shared package `uart_pkg` contains:
  - FSM state encoding localparams (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3), reused by future UART blocks.
  - A constant function computing `BAUD_CNT_MAX` from `CLK_FREQ`/`UART_BPS`.
- One sub-module, `sync_2ff` (1-bit, reset value parameter `INIT=1`), instantiated for `uart_rxd`.
- Everything else is flat in `uart_rx`.

## Test plan
- Byte 8'hA5 at 115200 baud with default parameters:
  - one `uart_rx_done` pulse at t0+4125;
  - `uart_rx_data=8'hA5`;
  - `uart_rx_err` stays 0;
  - `uart_rx_busy` is high t0+2..t0+4124.
- Three back-to-back frames 8'h00, 8'hFF, 8'h55 with one stop bit each and no idle gap:
  - three done pulses exactly 10·434 cycles apart;
  - data 8'h00, 8'hFF, 8'h55 in order.
- 100-cycle low glitch on an idle line:
  - returns to IDLE at the start-sample check;
  - `uart_rx_busy` high only t0+2..t0+218;
  - no done or err pulse.
- Frame 8'h3C with the stop bit driven 0, then the line held low for 2 bit times, then high:
  - one `uart_rx_err` pulse;
  - `uart_rx_data` keeps its previous value;
  - no new frame starts until the line rises and then falls.
- Assert `rst` for 3 cycles during data bit 4 of a 8'hC3 frame, then send 8'h81:
  - all outputs return to reset values during reset;
  - no pulse for the aborted frame;
  - 8'h81 is then received correctly.
- ±2% baud error on the transmitter side, data 8'h96 at both extremes: received correctly at both.
